// File: rtl/icache_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_fill_responder
// Description : Memory-side refill responder for the instruction cache. It
//               fetches one line word-by-word from a word-wide memory and
//               returns it with a single-cycle ready pulse. Optional macro
//               ICACHE_CRITICAL_WORD_FIRST_EN starts at the requested word.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_line_fill_responder #(
    parameter int unsigned ADDRESS_SIZE  = 40,
    parameter int unsigned I_WORD_SIZE   = 32,
    parameter int unsigned N_WORDS_BLOCK = 4,
    parameter int unsigned MEM_BUS       = 128
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    m_strobe_i,
    input  logic [ADDRESS_SIZE-1:0] m_a_i,
    output logic [MEM_BUS-1:0]      mdout_o,
    output logic                    m_ready_o,
    output logic                    w_req_o,
    output logic [ADDRESS_SIZE-1:0] w_addr_o,
    input  logic                    w_gnt_i,
    input  logic                    w_rvalid_i,
    input  logic [I_WORD_SIZE-1:0]  w_rdata_i
);

    localparam int unsigned INDEX_WORD_BITS = $clog2(N_WORDS_BLOCK);
    localparam int unsigned c_BASE_BITS     = ADDRESS_SIZE - INDEX_WORD_BITS;
    localparam logic [INDEX_WORD_BITS:0]   c_LAST_CNT = (INDEX_WORD_BITS+1)'(N_WORDS_BLOCK - 1);
    localparam logic [INDEX_WORD_BITS:0]   c_CNT_ONE  = (INDEX_WORD_BITS+1)'(1);
    localparam logic [INDEX_WORD_BITS-1:0] c_IDX_ONE  = (INDEX_WORD_BITS)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_BASE_BITS-1:0]     r_base;
    logic [INDEX_WORD_BITS-1:0] r_idx;
    logic [INDEX_WORD_BITS:0]   r_cnt;
    logic [I_WORD_SIZE-1:0]     r_words [N_WORDS_BLOCK];
    logic [MEM_BUS-1:0]         w_line;
    logic [MEM_BUS-1:0]         r_mdout;
    logic                       r_ready;
    logic [INDEX_WORD_BITS-1:0] w_start_idx;
    logic                       w_line_match;
    logic                       w_start;
    logic                       w_store;
    logic                       w_deliver;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign w_start_idx = m_a_i[INDEX_WORD_BITS-1:0];
`else
    logic w_unused_offset;
    assign w_unused_offset = ^m_a_i[INDEX_WORD_BITS-1:0];
    assign w_start_idx     = '0;
`endif

    assign w_line_match = (m_a_i[ADDRESS_SIZE-1:INDEX_WORD_BITS] == r_base);

    // Slots are placed by word index regardless of fetch order.
    for (genvar k = 0; k < N_WORDS_BLOCK; k++) begin : g_line_pack
        assign w_line[k*I_WORD_SIZE +: I_WORD_SIZE] = r_words[k];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_o      = 1'b0;
        w_start      = 1'b0;
        w_store      = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m_strobe_i) begin
                    w_start      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_req_o = 1'b1;
                if (w_gnt_i) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rvalid_i) begin
                    w_store      = 1'b1;
                    w_state_next = (r_cnt == c_LAST_CNT) ? S_RESP : S_REQ;
                end
            end
            S_RESP: begin
                // A dropped strobe or a different line discards the fill silently.
                if (m_strobe_i && w_line_match) begin
                    w_deliver    = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_base  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_mdout <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_start) begin
                r_base <= m_a_i[ADDRESS_SIZE-1:INDEX_WORD_BITS];
                r_idx  <= w_start_idx;
                r_cnt  <= '0;
            end
            if (w_store) begin
                r_idx <= r_idx + c_IDX_ONE;
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_deliver) begin
                r_ready <= 1'b1;
                r_mdout <= w_line;
            end
        end
    end

    // Line buffer needs no reset: it is only exposed after a complete fill.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_words[r_idx] <= w_rdata_i;
        end
    end

    assign w_addr_o  = {r_base, r_idx};
    assign mdout_o   = r_mdout;
    assign m_ready_o = r_ready;

endmodule
`default_nettype wire
